// File: rtl/wb_conbus_pkg.sv
// Shared constants and types for the round-robin Wishbone shared bus.
// Used by wb_conbus_rr and its arbiter.
package wb_conbus_pkg;

    localparam int ADR_W  = 32;
    localparam int DAT_W  = 32;
    localparam int SEL_W  = 4;
    localparam int NS_MAX = 8;

    localparam logic [17:0] DEF_S_ADDR_TABLE =
        {3'o6, 3'o5, 3'o4, 3'o3, 3'o2, 3'o0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

endpackage

// File: rtl/conbus_rr_arb.sv
// Two-way round-robin bus arbiter.
// A grant is held for as long as the owner keeps its request high.
module conbus_rr_arb
    import wb_conbus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       last_grant
);

    state_t state;
    state_t state_nx;
    logic   last_nx;

    // next grant: lone requester wins, ties go to the non-last owner
    always_comb begin
        state_nx = state;
        last_nx  = last_grant;
        unique case (state)
            IDLE: begin
                if (req[0] && req[1])
                    state_nx = last_grant ? GNT0 : GNT1;
                else if (req[0])
                    state_nx = GNT0;
                else if (req[1])
                    state_nx = GNT1;
            end
            GNT0: begin
                if (!req[0]) begin
                    state_nx = IDLE;
                    last_nx  = 1'b0;
                end
            end
            GNT1: begin
                if (!req[1]) begin
                    state_nx = IDLE;
                    last_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // grant state and last owner, reset leaves m1 as last owner
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nx;
            last_grant <= last_nx;
        end
    end

    assign gnt = {state == GNT1, state == GNT0};

endmodule

// File: rtl/wb_conbus_rr.sv
// 2-master / NS-slave Wishbone shared bus with round-robin arbitration.
// Optional bus timeout enabled by defining WB_CONBUS_TIMEOUT_EN.
module wb_conbus_rr
    import wb_conbus_pkg::*;
#(
    parameter int                      NS           = 6,
    parameter int                      S_ADDR_W     = 3,
    parameter logic [NS*S_ADDR_W-1:0]  S_ADDR_TABLE = DEF_S_ADDR_TABLE,
    parameter int                      TIMEOUT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADR_W-1:0]    m0_adr_i,
    input  logic [DAT_W-1:0]    m0_dat_i,
    output logic [DAT_W-1:0]    m0_dat_o,
    input  logic [SEL_W-1:0]    m0_sel_i,
    input  logic                m0_we_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    output logic                m0_ack_o,
    output logic                m0_err_o,

    input  logic [ADR_W-1:0]    m1_adr_i,
    input  logic [DAT_W-1:0]    m1_dat_i,
    output logic [DAT_W-1:0]    m1_dat_o,
    input  logic [SEL_W-1:0]    m1_sel_i,
    input  logic                m1_we_i,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    output logic                m1_ack_o,
    output logic                m1_err_o,

    output logic [ADR_W-1:0]    s_adr_o,
    output logic [DAT_W-1:0]    s_dat_o,
    output logic [SEL_W-1:0]    s_sel_o,
    output logic                s_we_o,
    output logic [NS-1:0]       s_cyc_o,
    output logic [NS-1:0]       s_stb_o,
    input  logic [NS*DAT_W-1:0] s_dat_i,
    input  logic [NS-1:0]       s_ack_i
);

    logic [1:0]       gnt;
    logic             last_grant;
    logic [ADR_W-1:0] g_adr;
    logic [DAT_W-1:0] g_dat;
    logic [SEL_W-1:0] g_sel;
    logic             g_we;
    logic             g_cyc;
    logic             g_stb;
    logic             hit;
    logic [NS-1:0]    sel_oh;
    logic [DAT_W-1:0] rdat;
    logic             ack_sel;
    logic             ack;
    logic             unmapped;
    logic             tmo;
    logic             err_q;
    logic             err_own;
    logic             err_hold;
    logic [ADR_W-1:0] err_adr;

    conbus_rr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        ({m1_cyc_i, m0_cyc_i}),
        .gnt        (gnt),
        .last_grant (last_grant)
    );

    // granted master drives the shared slave bus
    always_comb begin
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_we  = 1'b0;
        g_cyc = 1'b0;
        g_stb = 1'b0;
        unique case (1'b1)
            gnt[0]: begin
                g_adr = m0_adr_i;
                g_dat = m0_dat_i;
                g_sel = m0_sel_i;
                g_we  = m0_we_i;
                g_cyc = m0_cyc_i;
                g_stb = m0_stb_i & m0_cyc_i;
            end
            gnt[1]: begin
                g_adr = m1_adr_i;
                g_dat = m1_dat_i;
                g_sel = m1_sel_i;
                g_we  = m1_we_i;
                g_cyc = m1_cyc_i;
                g_stb = m1_stb_i & m1_cyc_i;
            end
            default: ;
        endcase
    end

    // address decode, lowest matching slave wins
    always_comb begin
        hit    = 1'b0;
        sel_oh = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (g_adr[ADR_W-1 -: S_ADDR_W] ==
                S_ADDR_TABLE[i*S_ADDR_W +: S_ADDR_W]) begin
                hit    = 1'b1;
                sel_oh = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    // read data and ack from the selected slave
    always_comb begin
        rdat = '0;
        for (int i = 0; i < NS; i++) begin
            if (sel_oh[i])
                rdat = s_dat_i[i*DAT_W +: DAT_W];
        end
    end

    assign ack_sel  = |(s_ack_i & sel_oh);
    assign ack      = g_stb & ack_sel;
    assign unmapped = g_stb & ~hit;

    assign s_adr_o = g_adr;
    assign s_dat_o = g_dat;
    assign s_sel_o = g_sel;
    assign s_we_o  = g_we;
    assign s_cyc_o = g_cyc ? sel_oh : '0;
    assign s_stb_o = (g_stb & ~tmo) ? sel_oh : '0;

`ifdef WB_CONBUS_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST =
        {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 stall;

    // tmo_cnt holds the stalled cycles before this one; grant changes
    // always pass through IDLE, which already breaks the stall
    assign stall = g_stb & hit & ~ack_sel;
    assign tmo   = stall & (tmo_cnt == TMO_LAST);

    // stall counter, cleared on ack, error or idle bus
    always_ff @(posedge clk) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (!stall || tmo)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    // one registered err pulse per unmapped strobe/address
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q    <= 1'b0;
            err_own  <= 1'b0;
            err_hold <= 1'b0;
            err_adr  <= '0;
        end else begin
            err_q <= unmapped & ~(err_hold && g_adr == err_adr);
            if (unmapped) begin
                err_hold <= 1'b1;
                err_adr  <= g_adr;
                err_own  <= gnt[1];
            end else begin
                err_hold <= 1'b0;
            end
        end
    end

    assign m0_ack_o = gnt[0] & ack;
    assign m1_ack_o = gnt[1] & ack;
    assign m0_dat_o = gnt[0] ? rdat : '0;
    assign m1_dat_o = gnt[1] ? rdat : '0;
    assign m0_err_o = gnt[0] & ((err_q & ~err_own) | tmo);
    assign m1_err_o = gnt[1] & ((err_q & err_own) | tmo);

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Directed self-checking bench for wb_conbus_rr.
// Timeout scenario built only when WB_CONBUS_TIMEOUT_EN is defined.
module tb_wb_conbus_rr;

`ifdef WB_CONBUS_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 8;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  m0_adr_i, m0_dat_i, m0_dat_o;
    logic [3:0]   m0_sel_i;
    logic         m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic [31:0]  m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]   m1_sel_i;
    logic         m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic [31:0]  s_adr_o, s_dat_o;
    logic [3:0]   s_sel_o;
    logic         s_we_o;
    logic [5:0]   s_cyc_o, s_stb_o;
    logic [191:0] s_dat_i;
    logic [5:0]   s_ack_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_conbus_rr #(.TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i),
        .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i),
        .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        s_ack_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_adr_i = 32'h10; m0_cyc_i = 1; m0_stb_i = 1;
        m1_adr_i = 32'h2000_0000; m1_cyc_i = 1; m1_stb_i = 1;
        s_ack_i = '1;
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if (s_cyc_o !== 6'b0 || s_stb_o !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_bus: cyc=%b stb=%b want 0", s_cyc_o, s_stb_o);
        end
        n_tests++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_resp: %b want 0000",
                     {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
        end
        idle_all();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_read();
        m0_adr_i = 32'h0000_0010; m0_we_i = 0; m0_sel_i = 4'hF;
        m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk);
        n_tests++;
        if (s_cyc_o !== 6'b0) begin
            n_fail++;
            $display("FAIL read_latency: cyc=%b want 000000", s_cyc_o);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (s_cyc_o !== 6'b000001 || s_stb_o !== 6'b000001 ||
            s_adr_o !== 32'h10) begin
            n_fail++;
            $display("FAIL read_sel: cyc=%b stb=%b adr=%h want 000001 000001 10",
                     s_cyc_o, s_stb_o, s_adr_o);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (m0_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL read_wait: ack=%b want 0", m0_ack_o);
        end
        tick();
        s_ack_i = 6'b000001;
        @(negedge clk);
        n_tests++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hC0DE_0000 ||
            m1_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL read_ack: ack=%b dat=%h m1ack=%b want 1 c0de0000 0",
                     m0_ack_o, m0_dat_o, m1_ack_o);
        end
        tick();
        s_ack_i = '0; m0_cyc_i = 0; m0_stb_i = 0;
        @(negedge clk);
        n_tests++;
        if (m0_ack_o !== 1'b0 || s_cyc_o !== 6'b0) begin
            n_fail++;
            $display("FAIL read_end: ack=%b cyc=%b want 0 000000",
                     m0_ack_o, s_cyc_o);
        end
        tick();
        tick();
    endtask

    task automatic test_round_robin();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m0_adr_i = 32'h0000_0010; m0_cyc_i = 1; m0_stb_i = 1;
        m1_adr_i = 32'h6000_0000; m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        @(negedge clk);
        n_tests++;
        if (s_cyc_o !== 6'b000001) begin
            n_fail++;
            $display("FAIL rr_first: cyc=%b want 000001", s_cyc_o);
        end
        tick();
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk);
        n_tests++;
        if (s_cyc_o !== 6'b0) begin
            n_fail++;
            $display("FAIL rr_idle_gap: cyc=%b want 000000", s_cyc_o);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (s_cyc_o !== 6'b000100) begin
            n_fail++;
            $display("FAIL rr_alt1: cyc=%b want 000100", s_cyc_o);
        end
        tick();
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        @(negedge clk);
        n_tests++;
        if (s_cyc_o !== 6'b000001) begin
            n_fail++;
            $display("FAIL rr_alt2: cyc=%b want 000001", s_cyc_o);
        end
        tick();
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        @(negedge clk);
        n_tests++;
        if (s_cyc_o !== 6'b000100) begin
            n_fail++;
            $display("FAIL rr_alt3: cyc=%b want 000100", s_cyc_o);
        end
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_write();
        m1_adr_i = 32'h6000_0004; m1_dat_i = 32'hDEAD_BEEF;
        m1_sel_i = 4'hF; m1_we_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        m0_adr_i = 32'h0000_0010; m0_cyc_i = 1; m0_stb_i = 1;
        s_ack_i = 6'b000101;
        @(negedge clk);
        n_tests++;
        if (s_stb_o !== 6'b000100 || s_cyc_o !== 6'b000100) begin
            n_fail++;
            $display("FAIL wr_sel: stb=%b cyc=%b want 000100", s_stb_o, s_cyc_o);
        end
        n_tests++;
        if (s_dat_o !== 32'hDEAD_BEEF || s_we_o !== 1'b1 ||
            s_sel_o !== 4'hF || s_adr_o !== 32'h6000_0004) begin
            n_fail++;
            $display("FAIL wr_bus: dat=%h we=%b sel=%h adr=%h want deadbeef 1 f 60000004",
                     s_dat_o, s_we_o, s_sel_o, s_adr_o);
        end
        n_tests++;
        if (m1_ack_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_ack: ack=%b want 1", m1_ack_o);
        end
        n_tests++;
        if (m0_ack_o !== 1'b0 || m0_dat_o !== 32'h0 || m0_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_m0: ack=%b dat=%h err=%b want 0 0 0",
                     m0_ack_o, m0_dat_o, m0_err_o);
        end
        tick();
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = '0;
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if (s_cyc_o !== 6'b000001) begin
            n_fail++;
            $display("FAIL stall_served: cyc=%b want 000001", s_cyc_o);
        end
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_unmapped();
        m1_adr_i = 32'h2000_0000; m1_we_i = 0; m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        @(negedge clk);
        n_tests++;
        if (s_stb_o !== 6'b0 || s_cyc_o !== 6'b0 || m1_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL um_first: stb=%b cyc=%b err=%b want 0 0 0",
                     s_stb_o, s_cyc_o, m1_err_o);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (m1_err_o !== 1'b1 || m0_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL um_err: m1err=%b m0err=%b want 1 0", m1_err_o, m0_err_o);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (m1_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL um_no_repeat: err=%b want 0", m1_err_o);
        end
        tick();
        m1_adr_i = 32'h3000_0000;
        @(negedge clk);
        n_tests++;
        if (m1_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL um_newadr_wait: err=%b want 0", m1_err_o);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (m1_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL um_newadr_err: err=%b want 1", m1_err_o);
        end
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        m0_adr_i = 32'h0000_0010; m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        m1_adr_i = 32'h6000_0000; m1_we_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        @(negedge clk);
        n_tests++;
        if (s_cyc_o !== 6'b000100) begin
            n_fail++;
            $display("FAIL rm_pre: cyc=%b want 000100", s_cyc_o);
        end
        rst = 1'b0;
        s_ack_i = 6'b000101;
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        @(negedge clk);
        n_tests++;
        if (s_cyc_o !== 6'b0 || s_stb_o !== 6'b0) begin
            n_fail++;
            $display("FAIL rm_bus: cyc=%b stb=%b want 0", s_cyc_o, s_stb_o);
        end
        n_tests++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL rm_resp: %b want 0000",
                     {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
        end
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_tests++;
        if (s_cyc_o !== 6'b000001 || m0_ack_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_last_grant: cyc=%b ack=%b want 000001 1",
                     s_cyc_o, m0_ack_o);
        end
        idle_all();
        tick();
        tick();
    endtask

`ifdef WB_CONBUS_TIMEOUT_EN
    task automatic test_timeout();
        m1_adr_i = 32'h8000_0000; m1_we_i = 0; m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_tests++;
            if (m1_err_o !== (k == 15) ||
                s_stb_o !== ((k == 15) ? 6'b0 : 6'b001000)) begin
                n_fail++;
                $display("FAIL tmo_cycle%0d: err=%b stb=%b", k, m1_err_o, s_stb_o);
            end
            tick();
        end
        idle_all();
        tick();
        tick();
    endtask
`else
    task automatic test_no_timeout();
        m1_adr_i = 32'h8000_0000; m1_we_i = 0; m1_cyc_i = 1; m1_stb_i = 1;
        for (int k = 0; k < 40; k++)
            tick();
        @(negedge clk);
        n_tests++;
        if (m1_err_o !== 1'b0 || s_stb_o !== 6'b001000) begin
            n_fail++;
            $display("FAIL hold_stall: err=%b stb=%b want 0 001000",
                     m1_err_o, s_stb_o);
        end
        idle_all();
        tick();
        tick();
    endtask
`endif

    initial begin
        for (int i = 0; i < 6; i++)
            s_dat_i[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);
        idle_all();
        rst = 1'b0;
        tick();
        test_reset();
        test_read();
        test_round_robin();
        test_write();
        test_unmapped();
        test_reset_mid();
`ifdef WB_CONBUS_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
